// File: rtl/i2c_target_if.sv
// Pin-side and host-side signals of the I2C target, bundled so the block has one bus port.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe_out;
    logic [7:0] rx_data_out;
    logic       rx_valid_out;
    logic       rx_ready_in;
    logic       tx_req_out;
    logic [7:0] tx_data_in;
    logic       busy_out;

    modport slave (
        input  scl_in, sda_in, rx_ready_in, tx_data_in,
        output sda_oe_out, rx_data_out, rx_valid_out, tx_req_out, busy_out
    );

    modport master (
        output scl_in, sda_in, rx_ready_in, tx_data_in,
        input  sda_oe_out, rx_data_out, rx_valid_out, tx_req_out, busy_out
    );
endinterface

// File: rtl/i2c_target.sv
// Byte-oriented 7-bit I2C target: oversampled and filtered SCL/SDA, START/STOP detection,
// write bytes out on a valid/ready stream, read bytes fetched through a req/data handshake.
module i2c_target #(
    parameter logic [6:0] ADDRESS    = 7'h50,
    parameter int         FILTER_LEN = 3
) (
    input logic         clk_in,
    input logic         rst_n_in,
    i2c_target_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, WR_NACK, RD_BYTE, RD_ACK, IGNORE
    } state_e;

    // Bit 0 carries SCL, bit 1 carries SDA through the synchronizer and filter.
    logic [1:0]      sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]      filt_q, filt_d, prev_q, prev_d;
    logic [1:0][2:0] cnt_q, cnt_d;

    state_e     state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d, tx_byte_q, tx_byte_d;
    logic       sda_oe_q, sda_oe_d, rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d, tx_load_q, tx_load_d, rw_q, rw_d;

    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] rx_byte;

    assign scl_f     = filt_q[0];
    assign sda_f     = filt_q[1];
    assign scl_rise  = scl_f & ~prev_q[0];
    assign scl_fall  = ~scl_f & prev_q[0];
    assign start_det = scl_f & prev_q[0] & ~sda_f & prev_q[1];
    assign stop_det  = scl_f & prev_q[0] & sda_f & ~prev_q[1];
    assign rx_byte   = {shift_q, sda_f};

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        sync1_d = {bus.sda_in, bus.scl_in};
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = 3'd0;
            end else if (cnt_q[i] == 3'(FILTER_LEN - 1)) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = 3'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 3'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        tx_load_d  = tx_req_q;
        tx_byte_d  = tx_load_q ? bus.tx_data_in : tx_byte_q;
        rw_d       = rw_q;

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            shift_d   = 7'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ADDR: if (scl_rise) begin
                    shift_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        rw_d      = sda_f;
                        state_d   = (shift_q == ADDRESS && ADDRESS != 7'd0) ? ADDR_ACK : IGNORE;
                    end
                end
                // First fall asserts the ACK; the rise marks the ACK clock; the next fall ends it.
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = WR_BYTE;
                        end
                    end else if (scl_rise) begin
                        if (rw_q) begin
                            tx_req_d  = 1'b1;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_BYTE;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end
                end
                WR_BYTE: if (scl_rise) begin
                    shift_d   = rx_byte[6:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        if (bus.rx_ready_in) begin
                            rx_data_d  = rx_byte;
                            rx_valid_d = 1'b1;
                            state_d    = WR_ACK;
                        end else begin
                            state_d = WR_NACK;
                        end
                    end
                end
                WR_ACK, WR_NACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd0) begin
                            sda_oe_d = (state_q == WR_ACK);
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = WR_BYTE;
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = 4'd1;
                    end
                end
                // The ACK-clock fall that enters this state also puts out bit 7.
                RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 4'd0;
                            state_d   = RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_byte_q[~bit_cnt_q[2:0]];
                        end
                    end else if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
                RD_ACK: if (scl_rise) begin
                    if (!sda_f) begin
                        tx_req_d  = 1'b1;
                        bit_cnt_d = 4'd0;
                        state_d   = RD_BYTE;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                IDLE, IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            prev_q     <= 2'b11;
            cnt_q      <= '0;
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 7'd0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            tx_load_q  <= 1'b0;
            tx_byte_q  <= 8'h00;
            rw_q       <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            prev_q     <= prev_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            tx_load_q  <= tx_load_d;
            tx_byte_q  <= tx_byte_d;
            rw_q       <= rw_d;
        end
    end

    assign bus.sda_oe_out   = sda_oe_q;
    assign bus.rx_data_out  = rx_data_q;
    assign bus.rx_valid_out = rx_valid_q;
    assign bus.tx_req_out   = tx_req_q;
    assign bus.busy_out     = state_q inside {ADDR_ACK, WR_BYTE, WR_ACK, WR_NACK, RD_BYTE, RD_ACK};
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level I2C master on a wired-AND SDA line, checked against a
// transaction-level model of which bytes get ACKed, delivered and read back.
module tb_i2c_target;
    localparam logic [6:0] TGT_ADDR = 7'h50;
    localparam int         FLEN     = 3;
    localparam int         Q        = 10;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_target_if bus ();

    i2c_target #(.ADDRESS(TGT_ADDR), .FILTER_LEN(FLEN)) dut (
        .clk_in  (clk),
        .rst_n_in(rst_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.scl_in = scl_m;
    assign bus.sda_in = sda_m & ~bus.sda_oe_out;

    int         n_vec = 0;
    int         n_err = 0;
    int         n_rxv = 0;
    int         n_txr = 0;
    int         tx_idx = 0;
    logic [7:0] got_rx[$];
    logic [7:0] tx_plan[$];
    logic [7:0] last_rx = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Host-side responder: records delivered bytes and serves planned read bytes on request.
    always @(negedge clk) begin
        if (bus.rx_valid_out) begin
            got_rx.push_back(bus.rx_data_out);
            n_rxv++;
        end
        if (bus.tx_req_out) begin
            n_txr++;
            bus.tx_data_in = (tx_idx < tx_plan.size()) ? tx_plan[tx_idx] : 8'hEE;
            tx_idx++;
        end
    end

    initial begin
        #(900_000);
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL clock: 10 clk low, 20 clk high; optional 1-clk SDA glitch while SCL is high.
    task automatic bit_xfer(input logic b, input logic glitch, output logic seen);
        wait_clk(4);
        sda_m = b;
        wait_clk(Q - 4);
        scl_m = 1'b1;
        wait_clk(5);
        if (glitch) begin
            sda_m = ~b;
            wait_clk(1);
            sda_m = b;
        end else begin
            wait_clk(1);
        end
        wait_clk(4);
        seen = bus.sda_in;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(4);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic [7:0] gm, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], gm[i], s);
        bit_xfer(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, 1'b0, s);
            d[i] = s;
        end
        bit_xfer(~mack, 1'b0, s);
    endtask

    task automatic wr_txn(input logic [6:0] a, input logic [7:0] dq[$], input logic rq[$],
                          input logic [7:0] gm, input bit do_stop);
        logic       ack;
        logic       match;
        int         rx0;
        logic [7:0] exp_q[$];
        match = (a == TGT_ADDR) && (a != 7'd0);
        rx0   = n_rxv;
        start_cond();
        write_byte({a, 1'b0}, 8'h00, ack);
        check("wr_addr_ack", ack, match);
        check("wr_busy_addr", bus.busy_out, match);
        foreach (dq[i]) begin
            bus.rx_ready_in = rq[i];
            write_byte(dq[i], gm, ack);
            check("wr_data_ack", ack, match & rq[i]);
            check("wr_busy_data", bus.busy_out, match);
            if (match && rq[i]) begin
                exp_q.push_back(dq[i]);
                last_rx = dq[i];
            end
        end
        if (do_stop) begin
            stop_cond();
            check("wr_busy_stop", bus.busy_out, 1'b0);
        end
        check("rx_count", n_rxv - rx0, exp_q.size());
        foreach (exp_q[k])
            check("rx_data", (rx0 + k < got_rx.size()) ? got_rx[rx0 + k] : 8'hxx, exp_q[k]);
        check("rx_hold", bus.rx_data_out, last_rx);
    endtask

    // Master ACKs every byte but the last, which it NACKs, then issues STOP.
    task automatic rd_txn(input logic [6:0] a, input logic [7:0] dq[$]);
        logic       ack;
        logic       match;
        int         tx0;
        logic [7:0] d;
        match = (a == TGT_ADDR) && (a != 7'd0);
        tx0   = n_txr;
        if (match) foreach (dq[i]) tx_plan.push_back(dq[i]);
        start_cond();
        write_byte({a, 1'b1}, 8'h00, ack);
        check("rd_addr_ack", ack, match);
        check("rd_busy_addr", bus.busy_out, match);
        if (match) begin
            foreach (dq[i]) begin
                read_byte(i != dq.size() - 1, d);
                check("rd_data", d, dq[i]);
            end
            wait_clk(8);
            check("rd_nack_release", bus.sda_oe_out, 1'b0);
            check("rd_busy_nack", bus.busy_out, 1'b0);
        end
        stop_cond();
        check("tx_req_count", n_txr - tx0, match ? dq.size() : 0);
    endtask

    initial begin
        logic [7:0] dq[$];
        logic       rq[$];
        logic [6:0] a;
        logic       ack;
        int         nb;

        bus.rx_ready_in = 1'b1;
        wait_clk(5);
        check("rst_sda_oe", bus.sda_oe_out, 1'b0);
        check("rst_rx_data", bus.rx_data_out, 8'h00);
        check("rst_rx_valid", bus.rx_valid_out, 1'b0);
        check("rst_tx_req", bus.tx_req_out, 1'b0);
        check("rst_busy", bus.busy_out, 1'b0);
        rst_n = 1'b1;
        wait_clk(2 * Q);

        dq = {8'h3C, 8'hFF};
        rq = {1'b1, 1'b1};
        wr_txn(TGT_ADDR, dq, rq, 8'h00, 1'b1);

        dq = {8'h12};
        rq = {1'b1};
        wr_txn(7'h51, dq, rq, 8'h00, 1'b1);

        dq = {8'h5A, 8'hC3};
        rd_txn(TGT_ADDR, dq);

        dq = {8'h77, 8'h21};
        rq = {1'b0, 1'b1};
        wr_txn(TGT_ADDR, dq, rq, 8'h00, 1'b1);

        dq = {8'h00};
        rq = {1'b1};
        wr_txn(7'h00, dq, rq, 8'h00, 1'b1);

        // Repeated START between a write and a read.
        dq = {8'h11};
        rq = {1'b1};
        wr_txn(TGT_ADDR, dq, rq, 8'h00, 1'b0);
        dq = {8'hB4};
        rd_txn(TGT_ADDR, dq);

        // SDA glitches while SCL is high on every data bit must be filtered out.
        dq = {8'h5A, 8'h96};
        rq = {1'b1, 1'b1};
        wr_txn(TGT_ADDR, dq, rq, 8'hFF, 1'b1);

        // Reset while the target is driving a 0 data bit.
        tx_plan.push_back(8'h00);
        start_cond();
        write_byte({TGT_ADDR, 1'b1}, 8'h00, ack);
        check("rst_addr_ack", ack, 1'b1);
        wait_clk(8);
        check("rst_pre_drive", bus.sda_oe_out, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_sda_oe", bus.sda_oe_out, 1'b0);
        check("rst_mid_rx_data", bus.rx_data_out, 8'h00);
        check("rst_mid_rx_valid", bus.rx_valid_out, 1'b0);
        check("rst_mid_tx_req", bus.tx_req_out, 1'b0);
        check("rst_mid_busy", bus.busy_out, 1'b0);
        sda_m = 1'b1;
        scl_m = 1'b1;
        last_rx = 8'h00;
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2 * Q);
        dq = {8'h42};
        rq = {1'b1};
        wr_txn(TGT_ADDR, dq, rq, 8'h00, 1'b1);

        for (int t = 0; t < 10; t++) begin
            a  = ($urandom_range(0, 3) != 0) ? TGT_ADDR : 7'($urandom_range(0, 127));
            nb = $urandom_range(1, 3);
            dq.delete();
            rq.delete();
            for (int k = 0; k < nb; k++) begin
                dq.push_back(8'($urandom));
                rq.push_back($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 1) == 0) wr_txn(a, dq, rq, 8'h00, 1'b1);
            else                           rd_txn(a, dq);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_target.md
# i2c_target

Byte-oriented I2C target (responder) for 7-bit addressing, the bus-facing counterpart to the team's I2C master. It oversamples SCL and SDA on the system clock, detects START and STOP conditions, and matches its address. Written bytes are delivered on a valid/ready stream; bytes for master reads are fetched through a request/data handshake. SDA is driven open-drain; clock stretching is not supported.

## Interface
- ADDRESS, 7'h50, 7-bit target address.
- FILTER_LEN, 3, consecutive identical samples required before a synchronized SCL/SDA level is accepted (1..8).
- clk_in  input  1  system clock; must be ≥ 20× SCL frequency.
- rst_n_in  input  1  reset; asynchronous assert, active-low.
- scl_in  input  1  raw SCL pin level.
- sda_in  input  1  raw SDA pin level.
- sda_oe_out  output  1  1 = pull SDA low, 0 = release.
- rx_data_out  output  8  last byte written by the master.
- rx_valid_out  output  1  one-cycle pulse; rx_data_out is valid.
- rx_ready_in  input  1  sampled on the 8th SCL rise of a write byte; 0 = NACK that byte.
- tx_req_out  output  1  one-cycle pulse requesting the next read byte.
- tx_data_in  input  8  read byte; latched on the cycle after tx_req_out.
- busy_out  output  1  1 while this target is addressed (ADDR_ACK through end of transaction).

## Operation
- Input path: 2-FF synchronizer per line, then a FILTER_LEN glitch filter. Filtered levels scl_f/sda_f reset to 1.
- Edge detect is on the filtered levels only.
  - START: sda_f falls while scl_f = 1.
  - STOP: sda_f rises while scl_f = 1.
  - Data bits are sampled MSB first on the scl_f rise.
  - sda_oe_out changes only on the cycle after an scl_f fall, or on STOP/START/reset.
- States:
  - IDLE → ADDR on START.
  - ADDR: shift 8 bits. At the 8th rise, if bits[7:1] == ADDRESS, go to ADDR_ACK. Otherwise go to IGNORE and release SDA until the next START/STOP.
  - ADDR_ACK: drive SDA low from the scl_f fall after bit 8 until the next scl_f fall. busy_out = 1.
    - R/W = 0 → WR_BYTE.
    - R/W = 1 → pulse tx_req_out on the ACK-bit scl_f rise, latch tx_data_in next cycle, go to RD_BYTE.
  - WR_BYTE: shift 8 bits.
    - At the 8th rise, if rx_ready_in = 1: update rx_data_out, pulse rx_valid_out in the same cycle, go to WR_ACK.
    - If rx_ready_in = 0: no pulse, go to WR_NACK.
  - WR_ACK: drive low for the 9th clock, then WR_BYTE. WR_NACK: release for the 9th clock, then WR_BYTE.
  - RD_BYTE: drive the latched byte MSB first, each bit set after an scl_f fall. A 1 bit means release. After the 8th bit's fall, release and go to RD_ACK.
  - RD_ACK: sample master ACK on the 9th rise.
    - sda_f = 0: pulse tx_req_out, latch tx_data_in next cycle, go to RD_BYTE.
    - sda_f = 1 (NACK): go to IGNORE.
- START in any state, including a repeated START, goes to ADDR, clears the bit counter and releases SDA. busy_out drops.
- STOP in any state goes to IDLE, releases SDA, busy_out = 0.
- START/STOP override an SCL edge detected in the same cycle.
- General call (address 0) is not acknowledged.
- Bit counter is 4 bits and resets to 0 at each byte boundary. There is no wrap beyond 9.

## Timing
- Reset values: sda_oe_out 0, rx_data_out 8'h00, rx_valid_out 0, tx_req_out 0, busy_out 0, state IDLE, filters 1.
- Reset mid-transfer releases SDA asynchronously. After reset the block waits for a fresh START.
- Pin to filtered-level latency: 2 + FILTER_LEN cycles.
- Pin SCL fall to sda_oe_out change: 2 + FILTER_LEN + 1 cycles.
- rx_valid_out: 1 cycle after the filtered 8th rise, concurrent with rx_data_out update. rx_data_out holds until the next accepted byte.
- tx_req_out: 1 cycle after the filtered rise of the ACK bit. tx_data_in must be stable on the following cycle. The first data bit drives after the next scl_f fall.
- SDA hold after an SCL fall is ≥ 3 + FILTER_LEN clocks. The 20× clock ratio guarantees the bit is set well before the next SCL rise.

## Test plan
- Write 0xA0 (addr 0x50, W), then 0x3C, 0xFF, STOP with rx_ready_in = 1 → 3 ACKs, rx_valid_out pulses twice with 0x3C then 0xFF, busy_out = 0 after STOP.
- Address 0x51 write → no ACK (SDA released on 9th clock), no rx_valid_out, busy_out stays 0.
- Read 0xA1 with tx_data_in = 0x5A then 0xC3; master ACKs the first byte and NACKs the second → SDA carries 0x5A then 0xC3, tx_req_out pulses exactly twice, SDA released after the NACK.
- Write with rx_ready_in = 0 at the 8th bit of byte 0x77 → NACK, no rx_valid_out; the next byte with ready = 1 is ACKed.
- Write 0xA0, 0x11, repeated START, 0xA1 read → ADDR re-entered, second address ACKed, tx_req_out pulse; rst_n_in low mid-byte releases SDA within 0 cycles and all outputs return to reset values.
- 1-cycle SDA glitch while SCL is high with FILTER_LEN = 3 → no START/STOP detected, state unchanged.
